// File: rtl/rgb_breath_pwm.sv
// Multi-channel PWM LED driver. Each channel is off, full-on, a static duty,
// or a breathing triangle ramp. Duties are reloaded only at PWM period wraps.
module rgb_breath_pwm #(
    parameter int PWM_BITS   = 8,
    parameter int CHANNELS   = 3,
    parameter int STEP_DIV   = 65536,
    parameter int HOLD_STEPS = 0,
    parameter int PHASE_STEP = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic [2*CHANNELS-1:0]        mode,
    input  logic [PWM_BITS*CHANNELS-1:0] level,
    output logic [CHANNELS-1:0]          pwm_out,
    output logic                         period_tick,
    output logic                         step_tick
);

    localparam logic [PWM_BITS-1:0] MAX       = '1;
    localparam int                  PS_W      = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PS_W-1:0]     PS_LAST   = PS_W'(STEP_DIV - 1);
    localparam int                  HOLD_W    = (HOLD_STEPS > 0) ? $clog2(HOLD_STEPS + 1) : 1;
    localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_STEPS);

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_ON      = 2'b01,
        MODE_STATIC  = 2'b10,
        MODE_BREATHE = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Reset brightness of channel c, saturated so a large stagger never wraps.
    function automatic logic [PWM_BITS-1:0] start_bright(input int c);
        longint v;
        v = longint'(c) * longint'(PHASE_STEP);
        if (v > ((longint'(1) << PWM_BITS) - 1))
            return MAX;
        return PWM_BITS'(v);
    endfunction

    logic [PS_W-1:0]     presc;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                stp;
    logic                wr;

    assign stp = enable && (presc == PS_LAST);
    assign wr  = enable && (pwm_cnt == MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc       <= '0;
            pwm_cnt     <= '0;
            period_tick <= 1'b0;
            step_tick   <= 1'b0;
        end else begin
            period_tick <= wr;
            step_tick   <= stp;
            if (enable) begin
                presc   <= stp ? '0 : presc + 1'b1;
                pwm_cnt <= pwm_cnt + 1'b1;
            end
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        mode_e               ch_mode;
        logic [PWM_BITS-1:0] ch_level;
        logic [PWM_BITS-1:0] bright;
        logic [PWM_BITS-1:0] shadow;
        logic [HOLD_W-1:0]   hold_cnt;
        dir_e                dir;
        logic                out_bit;

        assign ch_mode    = mode_e'(mode[2*c +: 2]);
        assign ch_level   = level[PWM_BITS*c +: PWM_BITS];
        assign pwm_out[c] = out_bit;

        // Breathing engine advances on every step regardless of mode.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                bright   <= start_bright(c);
                hold_cnt <= '0;
                dir      <= DIR_UP;
            end else if (stp) begin
                if (dir == DIR_UP) begin
                    if (bright != MAX) begin
                        bright <= bright + 1'b1;
                    end else if (hold_cnt != HOLD_LAST) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end else begin
                        hold_cnt <= '0;
                        dir      <= DIR_DOWN;
                        bright   <= MAX - 1'b1;
                    end
                end else begin
                    if (bright != '0) begin
                        bright <= bright - 1'b1;
                    end else if (hold_cnt != HOLD_LAST) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end else begin
                        hold_cnt <= '0;
                        dir      <= DIR_UP;
                        bright   <= PWM_BITS'(1);
                    end
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                shadow  <= '0;
                out_bit <= 1'b0;
            end else begin
                // NOTE: non-blocking assignment means a step in the same cycle
                // as the wrap is not yet visible here; shadow gets the old bright.
                if (wr) begin
                    case (ch_mode)
                        MODE_STATIC:  shadow <= ch_level;
                        MODE_BREATHE: shadow <= bright;
                        default:      shadow <= '0;
                    endcase
                end
                if (!enable) begin
                    out_bit <= 1'b0;
                end else begin
                    case (ch_mode)
                        MODE_OFF: out_bit <= 1'b0;
                        MODE_ON:  out_bit <= 1'b1;
                        default:  out_bit <= (pwm_cnt < shadow);
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_rgb_breath_pwm.sv
// Scoreboard bench for rgb_breath_pwm: expected per-period high counts are queued
// by the stimulus and compared by monitors at each period_tick.
module tb_rgb_breath_pwm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic [5:0]  mode = 6'b111111;
    logic [11:0] level = '0;
    logic [2:0]  pwm_out;
    logic        period_tick;
    logic        step_tick;

    logic        rst_b = 1'b1;
    logic        enable_b = 1'b1;
    logic [1:0]  mode_b = 2'b11;
    logic [3:0]  level_b = '0;
    logic [0:0]  pwm_b;
    logic        ptick_b;
    logic        stick_b;

    int checks = 0;
    int errors = 0;
    int ecyc = 0;
    bit b_done = 1'b0;

    typedef struct {
        string          tag;
        logic [2:0][4:0] duty;
        logic [2:0]     mask;
    } exp_t;

    exp_t exp_q[$];
    int   qb[$];

    always #5 clk = ~clk;

    rgb_breath_pwm #(
        .PWM_BITS(4), .CHANNELS(3), .STEP_DIV(4), .HOLD_STEPS(0), .PHASE_STEP(5)
    ) dut_a (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode), .level(level),
        .pwm_out(pwm_out), .period_tick(period_tick), .step_tick(step_tick)
    );

    rgb_breath_pwm #(
        .PWM_BITS(4), .CHANNELS(1), .STEP_DIV(16), .HOLD_STEPS(2), .PHASE_STEP(0)
    ) dut_b (
        .clk(clk), .rst(rst_b), .enable(enable_b), .mode(mode_b), .level(level_b),
        .pwm_out(pwm_b), .period_tick(ptick_b), .step_tick(stick_b)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Closed-form triangle for a 4-bit ramp starting at 0 going up.
    function automatic int tri_val(input int n, input int hold);
        int per;
        int p;
        per = 30 + 2 * hold;
        p   = n % per;
        if (p <= 15)             return p;
        else if (p <= 15 + hold) return 15;
        else if (p <= 30 + hold) return 30 + hold - p;
        else                     return 0;
    endfunction

    // Enabled clock edges since reset, as driven by the bench.
    always @(posedge clk or posedge rst) begin
        if (rst) ecyc <= 0;
        else if (enable) ecyc <= ecyc + 1;
    end

    task automatic wait_tick(input bit sel_b, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(sel_b ? ptick_b : period_tick) && n < 40);
        if (!(sel_b ? ptick_b : period_tick)) begin
            checks++;
            errors++;
            $display("FAIL tick_timeout dut=%0d waited=%0d limit=40", sel_b, n);
        end
    endtask

    task automatic push_breathe(input string tag);
        exp_t e;
        e.tag  = tag;
        e.mask = 3'b111;
        for (int c = 0; c < 3; c++)
            e.duty[c] = 5'(tri_val(ecyc / 4 - 1 + 5 * c, 0));
        exp_q.push_back(e);
    endtask

    task automatic push_static(input string tag, input int d0, input int d1, input int d2,
                               input logic [2:0] mask);
        exp_t e;
        e.tag     = tag;
        e.mask    = mask;
        e.duty[0] = 5'(d0);
        e.duty[1] = 5'(d1);
        e.duty[2] = 5'(d2);
        exp_q.push_back(e);
    endtask

    // Monitor A: high-cycle count per channel over [tick, next tick).
    int hc[3];
    bit win_open = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            win_open = 1'b0;
        end else begin
            if (period_tick) begin
                if (win_open && exp_q.size() > 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    for (int c = 0; c < 3; c++)
                        if (e.mask[c])
                            check($sformatf("%s_ch%0d", e.tag, c), hc[c], int'(e.duty[c]));
                end
                win_open = 1'b1;
                for (int c = 0; c < 3; c++) hc[c] = 0;
            end
            if (win_open)
                for (int c = 0; c < 3; c++) hc[c] += int'(pwm_out[c]);
        end
    end

    // Monitor B: hold/ramp instance, one breathing step per PWM period.
    int bhc = 0;
    bit bopen = 1'b0;
    always @(negedge clk) begin
        if (!rst_b) begin
            if (ptick_b) begin
                if (bopen && qb.size() > 0)
                    check("hold_ramp", bhc, qb.pop_front());
                bopen = 1'b1;
                bhc = 0;
            end
            if (bopen) bhc += int'(pwm_b[0]);
        end
    end

    // Stimulus B: window k carries bright after k-1 steps.
    initial begin
        int n;
        wait (rst_b == 1'b0);
        for (int k = 1; k <= 36; k++) begin
            wait_tick(1'b1, n);
            #1;
            if (k == 1) check("b_step_with_wrap", int'(stick_b), 1);
            qb.push_back(tri_val(k - 1, 2));
        end
        wait_tick(1'b1, n);
        b_done = 1'b1;
    end

    initial begin
        int n;
        int guard;

        repeat (3) @(negedge clk);
        check("rst_outputs", int'({pwm_out, period_tick, step_tick}), 0);
        rst   = 1'b0;
        rst_b = 1'b0;

        // Breathing from reset stagger 0/5/10.
        for (int k = 0; k < 5; k++) begin
            wait_tick(1'b0, n);
            #1;
            push_breathe("breathe");
        end

        n = 0;
        while (!step_tick && n < 10) begin @(negedge clk); n++; end
        n = 0;
        do begin @(negedge clk); n++; end while (!step_tick && n < 10);
        check("step_gap", n, 4);

        // Static duty, including 0 and MAX; level change mid-period.
        wait_tick(1'b0, n);
        #1;
        mode  = 6'b101010;
        level = {4'd15, 4'd0, 4'd6};
        wait_tick(1'b0, n);
        check("period_gap", n, 16);
        #1;
        push_static("static_a", 6, 0, 15, 3'b111);
        repeat (5) @(negedge clk);
        level[3:0] = 4'd12;
        wait_tick(1'b0, n);
        #1;
        push_static("static_b", 12, 0, 15, 3'b111);
        wait_tick(1'b0, n);
        #1;

        // Override: full-on then off act on the next clock.
        mode[1:0] = 2'b01;
        @(negedge clk);
        check("override_on", int'(pwm_out[0]), 1);
        #1;
        mode[1:0] = 2'b00;
        @(negedge clk);
        check("override_off", int'(pwm_out[0]), 0);
        #1;
        mode = 6'b111111;
        push_static("shadow_stable", 0, 0, 15, 3'b110);
        wait_tick(1'b0, n);
        #1;
        push_breathe("resume_ramp");
        wait_tick(1'b0, n);
        #1;

        // Enable low: outputs and ticks forced low, counters frozen.
        mode[1:0] = 2'b01;
        repeat (3) @(negedge clk);
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("enable_off", int'({pwm_out, period_tick, step_tick}), 0);
        end
        enable    = 1'b1;
        mode[1:0] = 2'b11;
        wait_tick(1'b0, n);
        check("resume_phase", ecyc % 16, 0);
        #1;
        push_breathe("after_pause");
        n = 0;
        while (!step_tick && n < 10) begin @(negedge clk); n++; end
        check("step_phase", ecyc % 4, 0);
        wait_tick(1'b0, n);
        #1;

        // Asynchronous reset mid-period.
        mode[1:0] = 2'b01;
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async", int'({pwm_out, period_tick, step_tick}), 0);
        mode = 6'b111111;
        repeat (2) @(negedge clk);
        check("rst_hold", int'({pwm_out, period_tick, step_tick}), 0);
        rst = 1'b0;
        wait_tick(1'b0, n);
        check("first_period", n, 16);
        #1;
        push_breathe("post_rst");
        wait_tick(1'b0, n);

        guard = 0;
        while (!b_done && guard < 3000) begin @(negedge clk); guard++; end
        if (!b_done) begin
            checks++;
            errors++;
            $display("FAIL hold_run_timeout done=%0d waited=%0d", b_done, guard);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rgb_breath_pwm.md
Name: rgb_breath_pwm

Overview:
- Multi-channel PWM LED driver with a per-channel mode: off, full-on, static level, or breathing triangle ramp.
- Counter width, channel count, breathing step rate, dwell at the ramp extremes and per-channel phase stagger are all set by parameters.
- Duty updates are glitch-free: a shadow register per channel is reloaded only at PWM period boundaries.
- Drives the board RGB LED directly, or any LED bank behind a status block.

Parameters:
- PWM_BITS, 8, PWM counter and duty width; MAX = 2^PWM_BITS-1.
- CHANNELS, 3, number of independent outputs.
- STEP_DIV, 65536, clk cycles (with enable=1) per breathing step; must be >= 1.
- HOLD_STEPS, 0, extra steps a breathing channel dwells at MAX and at 0.
- PHASE_STEP, 0, reset brightness offset per channel index.

Ports:
- clk  in  1  system clock (27 MHz on board).
- rst  in  1  asynchronous reset, active-high.
- enable  in  1  1 = run; 0 = freeze all counters, force outputs low, retain state.
- mode  in  2*CHANNELS  per channel, [2c+1:2c]: 00 off, 01 full-on, 10 static, 11 breathe.
- level  in  PWM_BITS*CHANNELS  static duty per channel, [PWM_BITS*c +: PWM_BITS].
- pwm_out  out  CHANNELS  registered PWM outputs.
- period_tick  out  1  one-cycle pulse per PWM period.
- step_tick  out  1  one-cycle pulse per breathing step.

Behaviour:
- Reset values, applied asynchronously:
  - pwm_out=0, period_tick=0, step_tick=0.
  - pwm_cnt=0, prescaler=0, hold_cnt[c]=0, dir[c]=up, shadow[c]=0.
  - bright[c]=min(c*PHASE_STEP, MAX).
- Prescaler: counts 0..STEP_DIV-1 while enable=1. The internal strobe stp is true when the count equals STEP_DIV-1; the count then wraps to 0. step_tick <= stp, so the pulse follows one cycle later. With STEP_DIV=1, stp is true every cycle.
- PWM counter: pwm_cnt increments modulo 2^PWM_BITS while enable=1. Wrap strobe wr = (pwm_cnt==MAX). period_tick <= wr, so the pulse coincides with pwm_cnt==0.
- Shadow reload, on wr, per channel:
  - mode 10: shadow <= level[c].
  - mode 11: shadow <= bright[c], using the pre-update value if stp fires in the same cycle.
  - mode 00 or 01: shadow <= 0.
  - Between wraps, shadow is stable regardless of mode or level changes.
- Output, registered, one-cycle latency:
  - enable=0: pwm_out[c] <= 0.
  - mode 00: 0.
  - mode 01: 1.
  - mode 10 or 11: pwm_cnt < shadow[c].
  - Mode 00/01 take effect on the next clock. Mode 10/11 take effect at the next period.
  - Duty 0 gives a constant 0; duty MAX gives MAX/2^PWM_BITS high.
- Breathing engine: runs on every channel on each stp, independent of mode, so switching to mode 11 resumes mid-ramp.
  - dir=up, bright<MAX: bright+1.
  - dir=up, bright==MAX, hold_cnt<HOLD_STEPS: hold_cnt+1.
  - dir=up, bright==MAX, hold_cnt==HOLD_STEPS: hold_cnt<=0, dir<=down, bright<=MAX-1 in the same step.
  - dir=down: mirror image, with dwell at 0, then dir<=up and bright<=1.
  - Triangle period = 2*MAX + 2*HOLD_STEPS steps.
  - No wrap-around: bright never exceeds MAX and never underflows below 0.
- Simultaneous stp and wr: shadow captures the old bright; the new value is seen at the next wrap.
- enable 1->0: all counters hold; outputs are 0 on the next edge.
- enable 0->1: counters resume from their held values; there is no resync.
- rst asserted mid-period: everything clears immediately; the first post-reset period starts at pwm_cnt=0.

Test Plan:
- Reset: PWM_BITS=4, CHANNELS=3, PHASE_STEP=5 -> during rst, pwm_out=000 and ticks=0. After release, bright = 0, 5, 10 (check via mode 11 duty).
- Static duty: mode=10, level=6, PWM_BITS=4 -> after the first period_tick, pwm_out high for exactly 6 of every 16 cycles. Changing level to 12 mid-period leaves the current period at 6 high cycles; the next period has 12.
- Breathe: PWM_BITS=4, STEP_DIV=4, HOLD_STEPS=0 -> step_tick every 4 cycles. bright sequence 0,1,...,15,14,...,0,1, period 30 steps. bright is never 16, never wraps.
- Hold: HOLD_STEPS=2 -> bright stays 15 for 3 consecutive steps and 0 for 3 steps. Period 34 steps.
- Override: mode switches 11 -> 01 -> 00 -> pwm_out=1 on the next cycle, then 0 on the next cycle. Back to 11: ramp continues from the engine's current bright at the next wrap.
- Enable/reset: deassert enable for 10 cycles -> outputs 0, pwm_cnt and prescaler frozen, resume at the same values. Assert rst mid-period -> pwm_out=0 immediately, all state at reset values.
